// File: rtl/tx_seq_pkg.sv
// Shared types and step arithmetic for the transmit modulation sequencer.
// Both the FSM top and the ramp stepper use these definitions.
package tx_seq_pkg;

    localparam int CTRL_W_DEF = 4;
    localparam int MOD_W_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_DOWN = 3'd1,
        ST_SWITCH    = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RAMP_UP   = 3'd4
    } state_t;

    // Difference is taken at 32 bits, wider than MOD_W+1, so full-scale jumps cannot wrap.
    function automatic int step_toward(input int mod, input int target, input int step);
        int diff;
        diff = target - mod;
        if (diff > step)
            return mod + step;
        else if (diff < -step)
            return mod - step;
        else
            return target;
    endfunction

endpackage

// File: rtl/tx_mod_sequencer_ramp_stepper.sv
// Prescaled ramp register: moves mod toward target by at most STEP once every RAMP_DIV cycles.
// A clear restarts the prescaler so the first step lands RAMP_DIV cycles later.
module ramp_stepper
    import tx_seq_pkg::*;
#(
    parameter int MOD_W    = MOD_W_DEF,
    parameter int STEP     = 64,
    parameter int RAMP_DIV = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic signed [MOD_W-1:0] target,
    output logic signed [MOD_W-1:0] mod,
    output logic                    at_target
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0]            presc;
    logic                     ramp_tick;
    logic signed [MOD_W-1:0]  next_mod;

    always_comb begin
        ramp_tick = enable && (presc == PW'(RAMP_DIV - 1));
        next_mod  = MOD_W'(step_toward(int'(mod), int'(target), STEP));
        at_target = (mod == target);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            mod   <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (ramp_tick) begin
            presc <= '0;
            mod   <= next_mod;
        end else if (enable) begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/tx_mod_sequencer.sv
// Sequences TX core control word and modulation value: ramp mod to 0, switch ctrl,
// settle, then ramp up to the requested target. Abort ramps to 0 and returns idle.
module tx_mod_sequencer
    import tx_seq_pkg::*;
#(
    parameter int CTRL_W        = CTRL_W_DEF,
    parameter int MOD_W         = MOD_W_DEF,
    parameter int STEP          = 64,
    parameter int RAMP_DIV      = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_req_valid,
    output logic                    io_req_ready,
    input  logic [CTRL_W-1:0]       io_req_ctrl,
    input  logic signed [MOD_W-1:0] io_req_mod,
    input  logic                    io_abort,
    output logic [CTRL_W-1:0]       io_ctrl,
    output logic signed [MOD_W-1:0] io_mod_value,
    output logic                    io_busy,
    output logic                    io_done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [CTRL_W-1:0]       tgt_ctrl;
    logic signed [MOD_W-1:0] tgt_mod;
    logic                    aborting;
    logic [SW-1:0]           settle_cnt;

    logic                    accept;
    logic                    abort_hit;
    logic                    ramp_clear;
    logic                    ramp_enable;
    logic                    load_ctrl;
    logic                    finish;
    logic                    at_target;
    logic signed [MOD_W-1:0] ramp_target;

    always_comb begin
        io_req_ready = (state == ST_IDLE) && !io_abort;
        io_busy      = (state != ST_IDLE);
        accept       = io_req_valid && io_req_ready;
        abort_hit    = io_abort && (state != ST_IDLE);
        ramp_enable  = (state == ST_RAMP_DOWN) || (state == ST_RAMP_UP);
        ramp_target  = (state == ST_RAMP_UP) ? tgt_mod : '0;
    end

    always_comb begin
        state_nxt  = state;
        ramp_clear = 1'b0;
        load_ctrl  = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt  = (io_req_ctrl == io_ctrl) ? ST_RAMP_UP : ST_RAMP_DOWN;
                    ramp_clear = 1'b1;
                end
            end
            ST_RAMP_DOWN: begin
                if (at_target)
                    state_nxt = aborting ? ST_IDLE : ST_SWITCH;
            end
            ST_SWITCH: begin
                state_nxt = ST_SETTLE;
                load_ctrl = 1'b1;
            end
            ST_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_nxt  = ST_RAMP_UP;
                    ramp_clear = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                if (at_target) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides every transition, including a pending ctrl load in SWITCH.
        if (abort_hit) begin
            state_nxt  = ST_RAMP_DOWN;
            ramp_clear = 1'b1;
            load_ctrl  = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            io_ctrl    <= '0;
            io_done    <= 1'b0;
            tgt_ctrl   <= '0;
            tgt_mod    <= '0;
            aborting   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state   <= state_nxt;
            io_done <= finish;
            if (load_ctrl)
                io_ctrl <= tgt_ctrl;
            if (accept) begin
                tgt_ctrl <= io_req_ctrl;
                tgt_mod  <= io_req_mod;
                aborting <= 1'b0;
            end else if (abort_hit) begin
                tgt_ctrl <= io_ctrl;
                tgt_mod  <= '0;
                aborting <= 1'b1;
            end
            if (state == ST_SETTLE && !abort_hit)
                settle_cnt <= settle_cnt + 1'b1;
            else
                settle_cnt <= '0;
        end
    end

    ramp_stepper #(
        .MOD_W    (MOD_W),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp (
        .clock     (clock),
        .reset     (reset),
        .enable    (ramp_enable),
        .clear     (ramp_clear),
        .target    (ramp_target),
        .mod       (io_mod_value),
        .at_target (at_target)
    );

endmodule

// File: tb/tb_tx_mod_sequencer.sv
// Directed bench for tx_mod_sequencer with STEP=64, RAMP_DIV=4, SETTLE_CYCLES=16.
module tb_tx_mod_sequencer;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_req_valid = 1'b0;
    logic              io_req_ready;
    logic [3:0]        io_req_ctrl = '0;
    logic signed [11:0] io_req_mod = '0;
    logic              io_abort = 1'b0;
    logic [3:0]        io_ctrl;
    logic signed [11:0] io_mod_value;
    logic              io_busy;
    logic              io_done;

    tx_mod_sequencer #(
        .CTRL_W        (4),
        .MOD_W         (12),
        .STEP          (64),
        .RAMP_DIV      (4),
        .SETTLE_CYCLES (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_ctrl  (io_req_ctrl),
        .io_req_mod   (io_req_mod),
        .io_abort     (io_abort),
        .io_ctrl      (io_ctrl),
        .io_mod_value (io_mod_value),
        .io_busy      (io_busy),
        .io_done      (io_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ctrl;
        int mod;
        int exp_ctrl;
        int exp_mod;
        int cycles;
        int up;
        int down;
        int last_delta;
        int hold;
    } vec_t;

    vec_t vecs[7];
    int n_checks = 0;
    int n_fail   = 0;

    int m_cycles, m_up, m_down, m_last, m_hold, m_done;
    int m_viol_ctrl, m_viol_step, m_ready_busy, m_timeout;
    int m_end_busy, m_end_ready;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Samples every cycle until done (or until idle when stop_idle is set).
    task automatic monitor(input bit stop_idle);
        int prev_mod, prev_ctrl, cur, d;
        bit ctrl_moved, finished;
        m_cycles = 0; m_up = 0; m_down = 0; m_last = 0; m_hold = 0; m_done = 0;
        m_viol_ctrl = 0; m_viol_step = 0; m_ready_busy = 0; m_timeout = 0;
        m_end_busy = -1; m_end_ready = -1;
        prev_mod = $signed(io_mod_value);
        prev_ctrl = int'(io_ctrl);
        ctrl_moved = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            m_cycles++;
            cur = $signed(io_mod_value);
            if (io_req_ready && io_busy) m_ready_busy++;
            if (cur != prev_mod) begin
                d = cur - prev_mod;
                if (d > 0) m_up++; else m_down++;
                if (d > 64 || d < -64) m_viol_step++;
                m_last = d;
            end
            if (int'(io_ctrl) != prev_ctrl) begin
                ctrl_moved = 1'b1;
                if (cur != 0 || prev_mod != 0) m_viol_ctrl++;
            end
            if (ctrl_moved && cur == 0) m_hold++;
            if (io_done) m_done++;
            prev_mod = cur;
            prev_ctrl = int'(io_ctrl);
            if ((!stop_idle && io_done) || (stop_idle && !io_busy)) begin
                m_end_busy = int'(io_busy);
                m_end_ready = int'(io_req_ready);
                finished = 1'b1;
                break;
            end
        end
        if (!finished) m_timeout = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, -1638, 0, -1638, 105,  0, 26, -38,  0};
        vecs[1] = '{0,   512, 0,   512, 137, 34,  0,  38,  0};
        vecs[2] = '{3,  1024, 3,  1024, 115, 16,  8,  64, 20};
        vecs[3] = '{3, -2048, 3, -2048, 193,  0, 48, -64,  0};
        vecs[4] = '{3,  2047, 3,  2047, 257, 64,  0,  63,  0};
        vecs[5] = '{3,  2047, 3,  2047,   1,  0,  0,   0,  0};
        vecs[6] = '{5,     0, 5,     0, 147,  0, 32, -63, 18};

        // Reset held for two cycles
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", int'(io_ctrl), 0);
        check("reset_mod", $signed(io_mod_value), 0);
        check("reset_ready", int'(io_req_ready), 1);
        check("reset_busy", int'(io_busy), 0);
        check("reset_done", int'(io_done), 0);
        reset = 1'b0;
        tick();

        // Table-driven requests
        foreach (vecs[k]) begin
            io_req_ctrl  = 4'(vecs[k].ctrl);
            io_req_mod   = 12'(vecs[k].mod);
            io_req_valid = 1'b1;
            tick();
            io_req_valid = 1'b0;
            monitor(1'b0);
            check($sformatf("v%0d_timeout", k), m_timeout, 0);
            check($sformatf("v%0d_cycles", k), m_cycles, vecs[k].cycles);
            check($sformatf("v%0d_mod", k), $signed(io_mod_value), vecs[k].exp_mod);
            check($sformatf("v%0d_ctrl", k), int'(io_ctrl), vecs[k].exp_ctrl);
            check($sformatf("v%0d_up", k), m_up, vecs[k].up);
            check($sformatf("v%0d_down", k), m_down, vecs[k].down);
            check($sformatf("v%0d_last_delta", k), m_last, vecs[k].last_delta);
            check($sformatf("v%0d_hold", k), m_hold, vecs[k].hold);
            check($sformatf("v%0d_ctrl_moved_nonzero", k), m_viol_ctrl, 0);
            check($sformatf("v%0d_step_too_big", k), m_viol_step, 0);
            check($sformatf("v%0d_ready_while_busy", k), m_ready_busy, 0);
            check($sformatf("v%0d_end_busy", k), m_end_busy, 0);
            check($sformatf("v%0d_end_ready", k), m_end_ready, 1);
            tick();
            check($sformatf("v%0d_done_pulse", k), int'(io_done), 0);
        end

        // Asynchronous reset in the middle of a ramp
        io_req_ctrl = 4'd5; io_req_mod = 12'sd1000; io_req_valid = 1'b1;
        tick();
        io_req_valid = 1'b0;
        repeat (20) tick();
        check("midramp_mod", $signed(io_mod_value), 320);
        #3 reset = 1'b1;
        #1;
        check("async_reset_mod", $signed(io_mod_value), 0);
        check("async_reset_ctrl", int'(io_ctrl), 0);
        check("async_reset_busy", int'(io_busy), 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Abort while idle blocks the request
        io_req_ctrl = 4'd1; io_req_mod = 12'sd100; io_req_valid = 1'b1; io_abort = 1'b1;
        #1;
        check("idle_abort_ready", int'(io_req_ready), 0);
        tick();
        io_req_valid = 1'b0; io_abort = 1'b0;
        check("idle_abort_busy", int'(io_busy), 0);

        // Abort during ramp to 1024 at mod=640
        io_req_ctrl = 4'd0; io_req_mod = 12'sd1024; io_req_valid = 1'b1;
        tick();
        io_req_valid = 1'b0;
        begin
            int waited;
            waited = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                waited++;
                if ($signed(io_mod_value) == 640) break;
            end
            check("abort_reach_640_cycles", waited, 40);
        end
        io_abort = 1'b1;
        tick();
        io_abort = 1'b0;
        monitor(1'b1);
        check("abort_timeout", m_timeout, 0);
        check("abort_cycles", m_cycles, 41);
        check("abort_down_ticks", m_down, 10);
        check("abort_up_ticks", m_up, 0);
        check("abort_no_done", m_done, 0);
        check("abort_mod", $signed(io_mod_value), 0);
        check("abort_ctrl", int'(io_ctrl), 0);
        check("abort_ready", int'(io_req_ready), 1);

        // Abort in SWITCH cancels the ctrl load
        io_req_ctrl = 4'd7; io_req_mod = 12'sd300; io_req_valid = 1'b1;
        tick();
        io_req_valid = 1'b0;
        tick();
        io_abort = 1'b1;
        tick();
        io_abort = 1'b0;
        check("switch_abort_ctrl", int'(io_ctrl), 0);
        monitor(1'b1);
        check("switch_abort_timeout", m_timeout, 0);
        check("switch_abort_ctrl_end", int'(io_ctrl), 0);
        check("switch_abort_no_done", m_done, 0);
        check("switch_abort_mod", $signed(io_mod_value), 0);

        // Back-pressure: second request held valid while busy
        io_req_ctrl = 4'd0; io_req_mod = 12'sd256; io_req_valid = 1'b1;
        tick();
        io_req_ctrl = 4'd2; io_req_mod = -12'sd128;
        monitor(1'b0);
        check("bp_a_timeout", m_timeout, 0);
        check("bp_a_ready_while_busy", m_ready_busy, 0);
        check("bp_a_up", m_up, 4);
        check("bp_a_mod", $signed(io_mod_value), 256);
        check("bp_a_ctrl", int'(io_ctrl), 0);
        check("bp_a_ready_on_done", m_end_ready, 1);
        tick();
        io_req_valid = 1'b0;
        check("bp_b_accepted_busy", int'(io_busy), 1);
        check("bp_b_done_low", int'(io_done), 0);
        monitor(1'b0);
        check("bp_b_timeout", m_timeout, 0);
        check("bp_b_mod", $signed(io_mod_value), -128);
        check("bp_b_ctrl", int'(io_ctrl), 2);
        check("bp_b_down", m_down, 6);
        check("bp_b_up", m_up, 0);
        check("bp_b_hold", m_hold, 20);
        check("bp_b_ctrl_moved_nonzero", m_viol_ctrl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
